regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Merges two writeback sources into one register-file write per cycle.
- Source A is the main pipeline writeback. It has priority and is never stalled.
- Source B is the secondary writeback (load/multi-cycle unit). It uses a valid/ready handshake and is held in a DEPTH-entry FIFO when A occupies the write slot.
- Also provides pending-write lookups so decode can stall on registers still waiting in the queue.

Parameters:
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
DEPTH, 4, B-queue entries; power of two, >=2

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
a_we  in  1  source A write request
a_addr  in  ADDR_WIDTH  source A destination register
a_wd  in  DATA_WIDTH  source A write data
b_valid  in  1  source B write request
b_addr  in  ADDR_WIDTH  source B destination register
b_wd  in  DATA_WIDTH  source B write data
b_ready  out  1  queue can accept B this cycle
we_out  out  1  register-file write enable (registered)
waddr_out  out  ADDR_WIDTH  register-file write address (registered)
wd_out  out  DATA_WIDTH  register-file write data (registered)
chk_addr1  in  ADDR_WIDTH  lookup address 1 (rs1)
chk_addr2  in  ADDR_WIDTH  lookup address 2 (rs2)
chk_hit1  out  1  a live queued write targets chk_addr1
chk_hit2  out  1  a live queued write targets chk_addr2
count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - we_out=0, waddr_out=0, wd_out=0, count=0.
  - All entries invalid; read/write pointers = 0.
  - b_ready=0 while rst=1.
  - Reset mid-operation discards all queued writes; none is issued.
- Address 0 (x0):
  - A request with addr 0 is ignored and does not use the slot.
  - A B handshake with addr 0 completes (accepted) but is never enqueued or issued.
- Handshake:
  - b_ready = !rst && (count<DEPTH).
  - B transfer occurs when b_valid && b_ready.
  - b_ready does not depend on b_valid or on same-cycle pops.
- Queue entry fields: addr, data, live bit.
- Slot selection, evaluated each cycle in priority order:
  1. A valid (a_we && a_addr!=0): issue A.
  2. Else, queue non-empty: pop head; issue it only if its live bit is set. A dead head pops with we_out=0.
  3. Else, queue empty and B transfer with addr!=0: bypass B directly to the outputs without enqueueing.
  4. Else: we_out=0.
- A B transfer not bypassed (and addr!=0) is enqueued at the tail with live=1.
- Push and pop may occur in the same cycle; count is unchanged.
- Latency: the issued write appears on we_out/waddr_out/wd_out in the cycle after the request edge. Exactly one cycle for A and for bypassed B.
- waddr_out/wd_out hold their last values when we_out=0.
- WAW ordering: A is always the youngest writer.
  - An A write to address X clears the live bit of every queued entry with addr X, in the same edge.
  - A B entry enqueued in the same cycle as an A write to the same X is enqueued with live=0.
  - A same-cycle B bypass cannot coexist with A, because A takes the slot.
  - Dead entries still occupy the queue until popped.
- Lookups (combinational):
  - chk_hitN=1 iff some valid entry with live=1 has addr==chk_addrN and chk_addrN!=0.
  - Registered state only; the same-cycle B input is not included.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Test Plan:
- Reset: rst=1 two cycles with b_valid=1 -> b_ready=0, we_out=0, count=0. Deassert -> b_ready=1.
- Bypass: idle queue; B writes x5=0x0000_00AA -> next cycle we_out=1, waddr_out=5, wd_out=0xAA; count stays 0.
- Contention and drain:
  - A writes x1..x4 on four consecutive cycles while B writes x10..x13 in the same cycles.
  - Expected: outputs x1,x2,x3,x4,x10,x11,x12,x13 in that order; count peaks at 4; b_ready=0 while count=4.
  - Additional B held off while full must not be lost.
- WAW kill:
  - Queue holds B x7=0x11 and A occupies the slot.
  - Next cycle A writes x7=0x22.
  - Expected: chk_hit1 for x7 drops to 0; later the x7=0x11 entry pops with we_out=0; last write to x7 is 0x22.
- x0 and wrap:
  - A writes x0 while the queue holds an entry -> head issues that cycle.
  - B x0 handshake -> accepted, count unchanged.
  - 3×DEPTH mixed writes -> every live write issued in order, pointers wrap correctly.
- Reset mid-drain: count=3, assert rst -> next cycle count=0, we_out=0; no queued write ever appears afterwards.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Merges a never-stalled primary writeback (A) and a queued secondary writeback (B)
// into one registered register-file write per cycle, with pending-write lookups.
module regfile_write_scheduler #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wd,
    input  logic                    b_valid,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wd,
    output logic                    b_ready,
    output logic                    we_out,
    output logic [ADDR_WIDTH-1:0]   waddr_out,
    output logic [DATA_WIDTH-1:0]   wd_out,
    input  logic [ADDR_WIDTH-1:0]   chk_addr1,
    input  logic [ADDR_WIDTH-1:0]   chk_addr2,
    output logic                    chk_hit1,
    output logic                    chk_hit2,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      live_q;
    logic [PW-1:0]         rd_q, wr_q;
    logic [PW:0]           count_q, count_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;

    logic a_v, b_xfer, empty, pop, bypass, push, push_live;

    assign b_ready   = !rst && (count_q < (PW+1)'(DEPTH));
    assign count     = count_q;
    assign we_out    = we_q;
    assign waddr_out = waddr_q;
    assign wd_out    = wd_q;

    always_comb begin
        a_v       = a_we && (a_addr != '0);
        b_xfer    = b_valid && b_ready;
        empty     = (count_q == '0);
        pop       = !a_v && !empty;
        bypass    = !a_v && empty && b_xfer && (b_addr != '0);
        push      = b_xfer && (b_addr != '0) && !bypass;
        // A is always the youngest writer, so a same-address B entering alongside it is born dead
        push_live = !(a_v && (a_addr == b_addr));
        count_d   = count_q + (PW+1)'(push) - (PW+1)'(pop);

        we_d    = 1'b0;
        waddr_d = waddr_q;
        wd_d    = wd_q;
        if (a_v) begin
            we_d    = 1'b1;
            waddr_d = a_addr;
            wd_d    = a_wd;
        end else if (pop) begin
            if (live_q[rd_q]) begin
                we_d    = 1'b1;
                waddr_d = addr_q[rd_q];
                wd_d    = data_q[rd_q];
            end
        end else if (bypass) begin
            we_d    = 1'b1;
            waddr_d = b_addr;
            wd_d    = b_wd;
        end
    end

    // Popped entries have their live bit cleared, so live alone marks valid pending writes
    always_comb begin
        chk_hit1 = 1'b0;
        chk_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && addr_q[i] == chk_addr1 && chk_addr1 != '0) chk_hit1 = 1'b1;
            if (live_q[i] && addr_q[i] == chk_addr2 && chk_addr2 != '0) chk_hit2 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            live_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wd_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (a_v && addr_q[i] == a_addr) live_q[i] <= 1'b0;
            end
            if (pop) begin
                live_q[rd_q] <= 1'b0;
                rd_q         <= rd_q + PW'(1);
            end
            if (push) begin
                addr_q[wr_q] <= b_addr;
                data_q[wr_q] <= b_wd;
                live_q[wr_q] <= push_live;
                wr_q         <= wr_q + PW'(1);
            end
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wd_q    <= wd_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed-vector bench for regfile_write_scheduler: per-cycle table plus a wrap/order sequence.
module tb_regfile_write_scheduler;
    logic        clk, rst;
    logic        a_we, b_valid, b_ready, we_out, chk_hit1, chk_hit2;
    logic [4:0]  a_addr, b_addr, waddr_out, chk_addr1, chk_addr2;
    logic [31:0] a_wd, b_wd, wd_out;
    logic [2:0]  count;

    regfile_write_scheduler #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd),
        .b_valid(b_valid), .b_addr(b_addr), .b_wd(b_wd), .b_ready(b_ready),
        .we_out(we_out), .waddr_out(waddr_out), .wd_out(wd_out),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_hit1(chk_hit1), .chk_hit2(chk_hit2), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, awe;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic [4:0]  c1, c2;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic        e_h1, e_h2, e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];
    int n_cmp = 0;
    int n_fail = 0;

    function automatic vec_t mk(logic r, logic awe, logic [4:0] aa, logic [31:0] ad,
                                logic bv, logic [4:0] ba, logic [31:0] bd,
                                logic [4:0] c1, logic [4:0] c2,
                                logic rdy, logic [2:0] cnt, logic h1, logic h2,
                                logic we, logic [4:0] wa, logic [31:0] wd);
        vec_t v;
        v.rst = r; v.awe = awe; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.c1 = c1; v.c2 = c2; v.e_rdy = rdy; v.e_cnt = cnt; v.e_h1 = h1; v.e_h2 = h2;
        v.e_we = we; v.e_wa = wa; v.e_wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset, bypass
        tbl[0]  = mk(1,0,0,0,     1,3,'h33,   3,0,  0,0,0,0, 0,0,0);
        tbl[1]  = mk(1,0,0,0,     1,3,'h33,   3,0,  0,0,0,0, 0,0,0);
        tbl[2]  = mk(0,0,0,0,     0,0,0,      3,0,  1,0,0,0, 0,0,0);
        tbl[3]  = mk(0,0,0,0,     1,5,'hAA,   5,0,  1,0,0,0, 1,5,'hAA);
        tbl[4]  = mk(0,0,0,0,     0,0,0,      5,0,  1,0,0,0, 0,5,'hAA);
        // contention and drain, extra B held off while full
        tbl[5]  = mk(0,1,1,'h101, 1,10,'h1A0, 10,13, 1,0,0,0, 1,1,'h101);
        tbl[6]  = mk(0,1,2,'h102, 1,11,'h1A1, 10,13, 1,1,1,0, 1,2,'h102);
        tbl[7]  = mk(0,1,3,'h103, 1,12,'h1A2, 10,13, 1,2,1,0, 1,3,'h103);
        tbl[8]  = mk(0,1,4,'h104, 1,13,'h1A3, 10,13, 1,3,1,0, 1,4,'h104);
        tbl[9]  = mk(0,0,0,0,     1,14,'h1E4, 10,13, 0,4,1,1, 1,10,'h1A0);
        tbl[10] = mk(0,0,0,0,     1,14,'h1E4, 10,13, 1,3,0,1, 1,11,'h1A1);
        tbl[11] = mk(0,0,0,0,     0,0,0,      10,13, 1,3,0,1, 1,12,'h1A2);
        tbl[12] = mk(0,0,0,0,     0,0,0,      10,13, 1,2,0,1, 1,13,'h1A3);
        tbl[13] = mk(0,0,0,0,     0,0,0,      14,13, 1,1,1,0, 1,14,'h1E4);
        tbl[14] = mk(0,0,0,0,     0,0,0,      14,13, 1,0,0,0, 0,14,'h1E4);
        // WAW kill of a queued entry, and a same-cycle dead enqueue
        tbl[15] = mk(0,1,20,'h200,1,7,'h11,   7,0,  1,0,0,0, 1,20,'h200);
        tbl[16] = mk(0,1,7,'h22,  0,0,0,      7,0,  1,1,1,0, 1,7,'h22);
        tbl[17] = mk(0,0,0,0,     0,0,0,      7,0,  1,1,0,0, 0,7,'h22);
        tbl[18] = mk(0,0,0,0,     0,0,0,      7,0,  1,0,0,0, 0,7,'h22);
        tbl[19] = mk(0,1,8,'h80,  1,8,'h81,   8,0,  1,0,0,0, 1,8,'h80);
        tbl[20] = mk(0,0,0,0,     0,0,0,      8,0,  1,1,0,0, 0,8,'h80);
        // x0 handling
        tbl[21] = mk(0,1,9,'h90,  1,6,'h60,   6,0,  1,0,0,0, 1,9,'h90);
        tbl[22] = mk(0,1,0,'hDEAD,0,0,0,      6,0,  1,1,1,0, 1,6,'h60);
        tbl[23] = mk(0,0,0,0,     1,0,'h55,   0,0,  1,0,0,0, 0,6,'h60);
        tbl[24] = mk(0,0,0,0,     0,0,0,      0,0,  1,0,0,0, 0,6,'h60);
        // reset mid-drain with three queued writes
        tbl[25] = mk(0,1,1,'h1,   1,2,'h2,    4,2,  1,0,0,0, 1,1,'h1);
        tbl[26] = mk(0,1,1,'h1,   1,3,'h3,    4,2,  1,1,0,1, 1,1,'h1);
        tbl[27] = mk(0,1,1,'h1,   1,4,'h4,    4,2,  1,2,0,1, 1,1,'h1);
        tbl[28] = mk(1,0,0,0,     0,0,0,      4,2,  0,3,1,1, 0,0,0);
        tbl[29] = mk(0,0,0,0,     0,0,0,      4,2,  1,0,0,0, 0,0,0);
        tbl[30] = mk(0,0,0,0,     0,0,0,      4,2,  1,0,0,0, 0,0,0);
        tbl[31] = mk(0,0,0,0,     0,0,0,      4,2,  1,0,0,0, 0,0,0);

        rst = 1; a_we = 0; a_addr = 0; a_wd = 0; b_valid = 0; b_addr = 0; b_wd = 0;
        chk_addr1 = 0; chk_addr2 = 0;
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; a_we = tbl[i].awe; a_addr = tbl[i].aa; a_wd = tbl[i].ad;
            b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_wd = tbl[i].bd;
            chk_addr1 = tbl[i].c1; chk_addr2 = tbl[i].c2;
            #1;
            chk("b_ready", i, 32'(b_ready), 32'(tbl[i].e_rdy));
            chk("count",   i, 32'(count),   32'(tbl[i].e_cnt));
            chk("hit1",    i, 32'(chk_hit1), 32'(tbl[i].e_h1));
            chk("hit2",    i, 32'(chk_hit2), 32'(tbl[i].e_h2));
            @(posedge clk); #1;
            chk("we_out",    i, 32'(we_out),    32'(tbl[i].e_we));
            chk("waddr_out", i, 32'(waddr_out), 32'(tbl[i].e_wa));
            chk("wd_out",    i, wd_out,         tbl[i].e_wd);
        end

        // 3*DEPTH B writes interleaved with A every third cycle; B must emerge in order
        begin
            int bi = 0, bo = 0;
            logic a_fire, sent;
            for (int cyc = 0; cyc < 80 && bo < 12; cyc++) begin
                @(negedge clk);
                a_fire  = (cyc < 12) && (cyc % 3 == 0);
                a_we    = a_fire;
                a_addr  = 5'(1 + cyc / 3);
                a_wd    = 32'h400 + 32'(cyc);
                b_valid = (bi < 12);
                b_addr  = 5'(16 + bi);
                b_wd    = 32'h300 + 32'(bi);
                #1 sent = b_valid && b_ready;
                @(posedge clk); #1;
                if (sent) bi++;
                if (a_fire) begin
                    chk("wrap_a_addr", cyc, {27'd0, waddr_out} & {32{we_out}}, 32'(1 + cyc / 3));
                    chk("wrap_a_data", cyc, wd_out, 32'h400 + 32'(cyc));
                end else if (we_out) begin
                    chk("wrap_b_addr", cyc, 32'(waddr_out), 32'(16 + bo));
                    chk("wrap_b_data", cyc, wd_out, 32'h300 + 32'(bo));
                    bo++;
                end
            end
            a_we = 0; b_valid = 0;
            chk("wrap_b_issued", 0, 32'(bo), 32'd12);
            @(negedge clk);
            chk("wrap_count_end", 0, 32'(count), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
